// File: rtl/preg_free_list_ckpt_pkg.sv
// preg_free_list_ckpt_pkg: shared rename types, sizes and circular-pointer helper
package preg_free_list_ckpt_pkg;
  localparam int PHYS_REG_NUM = 192;
  localparam int ARCH_REG_NUM = 32;
  localparam int RENAME_WIDTH = 6;
  localparam int COMMIT_WIDTH = 6;
  localparam int CKPT_NUM = 8;
  localparam int PW = $clog2(PHYS_REG_NUM);
  localparam int FL_DEPTH = PHYS_REG_NUM - ARCH_REG_NUM;
  localparam int IW = $clog2(FL_DEPTH);
  localparam int CW = $clog2(CKPT_NUM);
  localparam int NW = $clog2(FL_DEPTH + 1);
  typedef logic [PW-1:0] preg_t;
  typedef logic [CW-1:0] ckpt_id_t;
  typedef struct packed {
    logic wrap;
    logic [IW-1:0] idx;
  } fl_ptr_t;
  // advance a pointer by n (n < depth); depth need not be a power of two
  function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t ptr, input int n, input int depth);
    int s;
    logic c;
    s = int'(ptr.idx) + n;
    c = s >= depth;
    return '{wrap: ptr.wrap ^ c, idx: IW'(c ? s - depth : s)};
  endfunction
endpackage

// File: rtl/preg_free_list_ckpt_mask_prefix_sum.sv
// preg_free_list_ckpt_mask_prefix_sum: per-lane exclusive popcount of a request mask plus total
module preg_free_list_ckpt_mask_prefix_sum #(
  parameter int WIDTH = 6,
  parameter int SW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         mask,
  output logic [WIDTH-1:0][SW-1:0] pre,
  output logic [SW-1:0]            total
);
  // running count: each lane sees the number of set bits below it
  always_comb begin
    total = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pre[i] = total;
      total = total + SW'(mask[i]);
    end
  end
endmodule

// File: rtl/preg_free_list_ckpt.sv
// preg_free_list_ckpt: circular physical-register free list with checkpoint recovery and flush
module preg_free_list_ckpt
  import preg_free_list_ckpt_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RENAME_WIDTH-1:0]    alloc_req_i,
  output logic                       alloc_ready_o,
  output logic [RENAME_WIDTH*PW-1:0] alloc_preg_o,
  input  logic [COMMIT_WIDTH-1:0]    free_req_i,
  input  logic [COMMIT_WIDTH*PW-1:0] free_preg_i,
  input  logic [COMMIT_WIDTH-1:0]    commit_alloc_i,
  input  logic                       ckpt_take_i,
  input  ckpt_id_t                   ckpt_id_i,
  input  logic                       recover_i,
  input  ckpt_id_t                   recover_id_i,
  input  logic                       flush_i,
  output logic [NW-1:0]              free_cnt_o
);
  localparam int AS = $clog2(RENAME_WIDTH + 1);
  localparam int FS = $clog2(COMMIT_WIDTH + 1);
  preg_t entry [FL_DEPTH];
  fl_ptr_t ckpt [CKPT_NUM];
  fl_ptr_t head, tail, cmt_head, head_next, tail_next, cmt_next, head_adv;
  logic [RENAME_WIDTH-1:0][AS-1:0] a_pre;
  logic [COMMIT_WIDTH-1:0][FS-1:0] f_pre, c_pre;
  logic [AS-1:0] a_tot;
  logic [FS-1:0] f_tot, c_tot;
  preg_t [RENAME_WIDTH-1:0] alloc_preg;
  logic fire, unused;
  preg_free_list_ckpt_mask_prefix_sum #(.WIDTH(RENAME_WIDTH)) u_alloc_sum (.mask(alloc_req_i), .pre(a_pre), .total(a_tot));
  preg_free_list_ckpt_mask_prefix_sum #(.WIDTH(COMMIT_WIDTH)) u_free_sum (.mask(free_req_i), .pre(f_pre), .total(f_tot));
  preg_free_list_ckpt_mask_prefix_sum #(.WIDTH(COMMIT_WIDTH)) u_cmt_sum (.mask(commit_alloc_i), .pre(c_pre), .total(c_tot));
  assign unused = ^c_pre;
  // distance from alloc head to free tail in the doubled index space
  function automatic logic [NW-1:0] ptr_dist(input fl_ptr_t t, input fl_ptr_t h);
    int lt, lh;
    lt = int'(t.wrap) * FL_DEPTH + int'(t.idx);
    lh = int'(h.wrap) * FL_DEPTH + int'(h.idx);
    return NW'(lt >= lh ? lt - lh : lt + 2 * FL_DEPTH - lh);
  endfunction
  assign free_cnt_o = ptr_dist(tail, head);
  assign alloc_ready_o = free_cnt_o >= NW'(a_tot);
  assign fire = |alloc_req_i && alloc_ready_o && !recover_i && !flush_i;
  assign head_adv = fl_ptr_add(head, int'(a_tot), FL_DEPTH);
  assign tail_next = fl_ptr_add(tail, int'(f_tot), FL_DEPTH);
  assign cmt_next = fl_ptr_add(cmt_head, int'(c_tot), FL_DEPTH);
  assign head_next = flush_i ? cmt_next : recover_i ? ckpt[recover_id_i] : fire ? head_adv : head;
  assign alloc_preg_o = alloc_preg;
  // each requesting lane reads the entry at head plus its rank among the requests
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) alloc_preg[i] = entry[fl_ptr_add(head, int'(a_pre[i]), FL_DEPTH).idx];
  end
  // pointers and checkpoint slots; recovery and flush suppress checkpoint capture
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      cmt_head <= '0;
      tail <= '{wrap: 1'b1, idx: '0};
      for (int i = 0; i < CKPT_NUM; i++) ckpt[i] <= '0;
    end else begin
      head <= head_next;
      cmt_head <= cmt_next;
      tail <= tail_next;
      if (ckpt_take_i && !recover_i && !flush_i) ckpt[ckpt_id_i] <= head_next;
    end
  end
  // entry storage: freed pregs land at tail in lane order; reset seeds the non-architectural pregs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FL_DEPTH; i++) entry[i] <= PW'(ARCH_REG_NUM + i);
    end else begin
      for (int i = 0; i < COMMIT_WIDTH; i++)
        if (free_req_i[i]) entry[fl_ptr_add(tail, int'(f_pre[i]), FL_DEPTH).idx] <= free_preg_i[i*PW+:PW];
    end
  end
  a_free_cnt_bound: assert property (@(posedge clk) disable iff (rst) free_cnt_o <= NW'(FL_DEPTH));
endmodule

// File: tb/tb_preg_free_list_ckpt.sv
// tb_preg_free_list_ckpt: directed scoreboard bench for the checkpointed free list
module tb_preg_free_list_ckpt;
  import preg_free_list_ckpt_pkg::*;
  logic clk = 0, rst = 1;
  logic [RENAME_WIDTH-1:0] alloc_req = '0;
  logic [COMMIT_WIDTH-1:0] free_req = '0, commit_alloc = '0;
  logic [COMMIT_WIDTH*PW-1:0] free_preg = '0;
  logic [RENAME_WIDTH*PW-1:0] alloc_preg;
  logic alloc_ready, ckpt_take = 0, recover = 0, flush = 0;
  ckpt_id_t ckpt_id = '0, recover_id = '0;
  logic [NW-1:0] free_cnt;
  always #5 clk = ~clk;
  preg_free_list_ckpt dut (
    .clk(clk), .rst(rst), .alloc_req_i(alloc_req), .alloc_ready_o(alloc_ready), .alloc_preg_o(alloc_preg),
    .free_req_i(free_req), .free_preg_i(free_preg), .commit_alloc_i(commit_alloc), .ckpt_take_i(ckpt_take),
    .ckpt_id_i(ckpt_id), .recover_i(recover), .recover_id_i(recover_id), .flush_i(flush), .free_cnt_o(free_cnt)
  );
  typedef struct {string tag; int v;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int m_ent [FL_DEPTH];
  int m_ck [CKPT_NUM];
  int m_head, m_tail, m_cmt;
  task automatic push(input string tag, input int v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop_chk(input logic [31:0] act);
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (act === 32'(e.v)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", e.tag, act, e.v);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; alloc_req = '1; free_req = '1; commit_alloc = '1; ckpt_take = 1; recover = 1; flush = 1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < FL_DEPTH; i++) m_ent[i] = ARCH_REG_NUM + i;
    for (int i = 0; i < CKPT_NUM; i++) m_ck[i] = 0;
    m_head = 0; m_cmt = 0; m_tail = FL_DEPTH;
    @(negedge clk);
    rst = 0; alloc_req = '0; free_req = '0; commit_alloc = '0; ckpt_take = 0; recover = 0; flush = 0;
    #1;
    push("rst_free_cnt", FL_DEPTH);
    push("rst_ready", 1);
    pop_chk(32'(free_cnt));
    pop_chk(32'(alloc_ready));
  endtask
  task automatic cycle(input logic [5:0] ar, input logic [5:0] fr, input int fbase, input logic [5:0] ca,
                       input logic tk, input int tid, input logic rc, input int rid, input logic fl);
    int cnt, pa, k, nh;
    logic rdy, fire;
    @(negedge clk);
    alloc_req = ar; free_req = fr; commit_alloc = ca; ckpt_take = tk; ckpt_id = CW'(tid);
    recover = rc; recover_id = CW'(rid); flush = fl;
    for (int i = 0; i < COMMIT_WIDTH; i++) free_preg[i*PW+:PW] = PW'(fbase + i);
    cnt = m_tail - m_head;
    pa = $countones(ar);
    rdy = cnt >= pa;
    push("alloc_ready", int'(rdy));
    k = 0;
    for (int i = 0; i < RENAME_WIDTH; i++)
      if (ar[i]) begin
        push($sformatf("alloc_preg_lane%0d", i), m_ent[(m_head + k) % FL_DEPTH]);
        k++;
      end
    #1;
    pop_chk(32'(alloc_ready));
    for (int i = 0; i < RENAME_WIDTH; i++) if (ar[i]) pop_chk(32'(alloc_preg[i*PW+:PW]));
    fire = |ar && rdy && !rc && !fl;
    nh = fl ? m_cmt + $countones(ca) : rc ? m_ck[rid] : fire ? m_head + pa : m_head;
    if (tk && !rc && !fl) m_ck[tid] = nh;
    k = 0;
    for (int i = 0; i < COMMIT_WIDTH; i++)
      if (fr[i]) begin
        m_ent[(m_tail + k) % FL_DEPTH] = fbase + i;
        k++;
      end
    m_tail += k;
    m_cmt += $countones(ca);
    m_head = nh;
    push("free_cnt", m_tail - m_head);
    @(posedge clk);
    #1;
    pop_chk(32'(free_cnt));
  endtask
  task automatic expect_cnt(input string tag, input int v);
    push(tag, v);
    pop_chk(32'(free_cnt));
  endtask
  initial begin
    do_reset();
    cycle(6'b101101, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_cnt("t1_free_cnt", 156);
    for (int c = 0; c < 25; c++) cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h03, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_cnt("drain_free_cnt", 4);
    cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_cnt("refused_free_cnt", 4);
    cycle(6'h0F, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_cnt("empty_free_cnt", 0);
    for (int c = 0; c < 26; c++) cycle(0, 6'h3F, 40 + (c * 5) % 140, 0, 0, 0, 0, 0, 0);
    cycle(0, 6'h03, 150, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 26; c++) cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h03, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 6'h0F, 170, 0, 0, 0, 0, 0, 0);
    expect_cnt("prewrap_free_cnt", 4);
    cycle(6'h0F, 6'h30, 120, 0, 0, 0, 0, 0, 0);
    expect_cnt("wrap_free_cnt", 2);
    cycle(6'h22, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(6'h03, 0, 0, 0, 1, 3, 0, 0, 0);
    cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h01, 0, 0, 0, 0, 0, 1, 3, 0);
    expect_cnt("recover_free_cnt", 158);
    cycle(6'h01, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h0F, 0, 0, 6'h0F, 0, 0, 0, 0, 0);
    cycle(6'h3F, 6'h03, 100, 0, 0, 0, 0, 0, 1);
    expect_cnt("flush_free_cnt", 158);
    cycle(6'h01, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h3F, 0, 0, 0, 1, 5, 0, 0, 0);
    cycle(6'h03, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h3F, 0, 0, 0, 1, 5, 1, 2, 1);
    expect_cnt("priority_free_cnt", 158);
    cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(6'h03, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 5, 0);
    expect_cnt("ckpt_kept_free_cnt", 151);
    cycle(6'h3F, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
